// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared opcodes, FSM states and sizing helpers for the GF(2^m) accumulator
package gf2m_pkg;
   localparam int MAXW = 256;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_XOR   = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_IN, S_OUT} state_t;
   function automatic int nwords(int m, int w);
      return (m + w - 1) / w;
   endfunction
   function automatic logic [MAXW-1:0] top_mask(int m, int w);
      return (MAXW'(1) << (m - (nwords(m, w) - 1) * w)) - MAXW'(1);
   endfunction
endpackage

// File: rtl/gf2m_xor_acc_if.sv
// gf2m_xor_acc_if: command, operand and result handshakes plus status for the accumulator
interface gf2m_xor_acc_if #(parameter int W = 8);
   logic         cmd_valid, cmd_ready;
   logic [1:0]   cmd_op;
   logic         in_valid, in_ready;
   logic [W-1:0] in_data;
   logic         out_valid, out_ready, out_last;
   logic [W-1:0] out_data;
   logic         busy, acc_zero;
   modport master (output cmd_valid, cmd_op, in_valid, in_data, out_ready,
                   input cmd_ready, in_ready, out_valid, out_data, out_last, busy, acc_zero);
   modport slave  (input cmd_valid, cmd_op, in_valid, in_data, out_ready,
                   output cmd_ready, in_ready, out_valid, out_data, out_last, busy, acc_zero);
endinterface

// File: rtl/gf2m_word_xor.sv
// gf2m_word_xor: one bus word of masked field addition (mode=1) or masked pass-through (mode=0)
module gf2m_word_xor #(parameter int W = 8) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] mask,
   input  logic         mode,
   output logic [W-1:0] y
);
   assign y = mode ? a ^ (b & mask) : b & mask;
endmodule

// File: rtl/gf2m_xor_acc.sv
// gf2m_xor_acc: word-serial GF(2^m) load/add/read/clear accumulator holding one canonical element
module gf2m_xor_acc
   import gf2m_pkg::*;
#(
   parameter int M = 163,
   parameter int W = 8
) (
   input logic            clk,
   input logic            rst,
   gf2m_xor_acc_if.slave  bus
);
   localparam int NW = nwords(M, W);
   localparam int IW = NW > 1 ? $clog2(NW) : 1;
   localparam logic [W-1:0]  TOP_MASK = W'(top_mask(M, W));
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [1:0]      op;
   logic [NW*W-1:0] acc;
   logic [W-1:0]    word, mask, res;
   logic            last, cmd_fire, in_fire, out_fire;
   assign word     = acc[idx*W +: W];
   assign last     = idx == LAST_IDX;
   assign mask     = last ? TOP_MASK : '1;
   assign cmd_fire = state == S_IDLE && bus.cmd_valid;
   assign in_fire  = state == S_IN && bus.in_valid;
   assign out_fire = state == S_OUT && bus.out_ready;
   gf2m_word_xor #(.W(W)) u_word_xor (
      .a(word), .b(bus.in_data), .mask(mask), .mode(op == OP_XOR), .y(res)
   );
   // Masking at the write port keeps bits >= M zero, so acc is always canonical
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         op    <= OP_LOAD;
         acc   <= '0;
      end else begin
         state <= state_nx;
         if (cmd_fire) op <= bus.cmd_op;
         if (cmd_fire && bus.cmd_op == OP_CLEAR) acc <= '0;
         if (in_fire) acc[idx*W +: W] <= res;
         if (in_fire || out_fire) idx <= last ? '0 : idx + 1'b1;
      end
   always_comb begin
      state_nx = state == S_IDLE ? (!cmd_fire ? S_IDLE :
                                    bus.cmd_op == OP_READ  ? S_OUT :
                                    bus.cmd_op == OP_CLEAR ? S_IDLE : S_IN) :
                 state == S_IN   ? (in_fire && last ? S_IDLE : S_IN) :
                                   (out_fire && last ? S_IDLE : S_OUT);
   end
   // Handshakes stay low while rst is held, even though the state is already IDLE
   always_comb begin
      bus.cmd_ready = state == S_IDLE && !rst;
      bus.in_ready  = state == S_IN && !rst;
      bus.out_valid = state == S_OUT && !rst;
      bus.out_data  = bus.out_valid ? word : '0;
      bus.out_last  = bus.out_valid && last;
      bus.busy      = state != S_IDLE;
      bus.acc_zero  = ~|acc;
   end
endmodule

// File: tb/tb_gf2m_xor_acc.sv
// tb_gf2m_xor_acc: directed scoreboard bench for the M=12 and M=163 accumulator configurations
module tb_gf2m_xor_acc;
   import gf2m_pkg::*;
   logic clk = 0, rst = 1, sel = 0;
   logic cmd_valid = 0, in_valid = 0, out_ready = 0;
   logic [1:0] cmd_op = OP_LOAD;
   logic [7:0] in_data = '0;
   logic cmd_ready, in_ready, out_valid, out_last, busy, acc_zero;
   logic [7:0] out_data;
   int checks = 0, errors = 0;
   int nw = 2;
   logic [7:0] tmask = 8'h0F;
   logic [7:0] mdl[21];
   logic [7:0] opnd[21];
   logic [7:0] exp_q[$];
   gf2m_xor_acc_if #(.W(8)) ba ();
   gf2m_xor_acc_if #(.W(8)) bb ();
   gf2m_xor_acc #(.M(12), .W(8)) dut_a (.clk(clk), .rst(rst), .bus(ba));
   gf2m_xor_acc #(.M(163), .W(8)) dut_b (.clk(clk), .rst(rst), .bus(bb));
   always #5 clk = ~clk;
   // Stimulus goes to the selected DUT only; the other sees idle inputs
   assign ba.cmd_valid = cmd_valid && !sel;
   assign bb.cmd_valid = cmd_valid && sel;
   assign ba.in_valid  = in_valid && !sel;
   assign bb.in_valid  = in_valid && sel;
   assign ba.out_ready = out_ready && !sel;
   assign bb.out_ready = out_ready && sel;
   assign ba.cmd_op = cmd_op;
   assign bb.cmd_op = cmd_op;
   assign ba.in_data = in_data;
   assign bb.in_data = in_data;
   assign cmd_ready = sel ? bb.cmd_ready : ba.cmd_ready;
   assign in_ready  = sel ? bb.in_ready  : ba.in_ready;
   assign out_valid = sel ? bb.out_valid : ba.out_valid;
   assign out_data  = sel ? bb.out_data  : ba.out_data;
   assign out_last  = sel ? bb.out_last  : ba.out_last;
   assign busy      = sel ? bb.busy      : ba.busy;
   assign acc_zero  = sel ? bb.acc_zero  : ba.acc_zero;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_zero();
      logic z = 1;
      for (int i = 0; i < nw; i++) if (mdl[i] != 0) z = 0;
      return z;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 21; i++) mdl[i] = 8'h00;
   endtask

   task automatic cmd(input logic [1:0] op);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1;
      cmd_op = op;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("cmd_accept", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic write_el(input logic [1:0] op, input bit gap, input bit xinj);
      logic [7:0] m;
      int n;
      cmd(op);
      for (int i = 0; i < nw; i++) begin
         if (gap) begin
            in_valid = 0;
            @(negedge clk);
            chk("stall_busy", busy, 1);
         end
         in_valid = 1;
         in_data = (xinj && i == 1) ? {4'bxxxx, opnd[i][3:0]} : opnd[i];
         n = 0;
         while (!in_ready && n < 50) begin @(negedge clk); n++; end
         chk("in_ready", in_ready, 1);
         @(negedge clk);
         m = opnd[i] & ((i == nw - 1) ? tmask : 8'hFF);
         mdl[i] = op == OP_XOR ? mdl[i] ^ m : m;
      end
      in_valid = 0;
      chk("write_done_busy", busy, 0);
      chk("write_b2b_ready", cmd_ready, 1);
      chk("write_acc_zero", acc_zero, model_zero());
   endtask

   task automatic read_el(input bit stall);
      logic [7:0] e;
      for (int i = 0; i < nw; i++) exp_q.push_back(mdl[i]);
      cmd(OP_READ);
      if (stall) begin
         out_ready = 0;
         for (int k = 0; k < 3; k++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, exp_q[0]);
            @(negedge clk);
         end
      end
      for (int i = 0; i < nw; i++) begin
         out_ready = 1;
         e = exp_q.pop_front();
         chk("read_valid", out_valid, 1);
         chk("read_data", out_data, e);
         chk("read_last", out_last, i == nw - 1);
         if (i == nw - 1) chk("read_top_bits", out_data & ~tmask, 0);
         @(negedge clk);
      end
      out_ready = 0;
      chk("read_done_busy", busy, 0);
      chk("idle_out_data", out_data, 0);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      model_clear();
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      rst = 0;
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_acc_zero", acc_zero, 1);
      chk("post_rst_out_data", out_data, 0);
      // 1: load with top-word masking, then read
      opnd[0] = 8'hA5; opnd[1] = 8'hF3;
      write_el(OP_LOAD, 0, 0);
      chk("t1_acc_nonzero", acc_zero, 0);
      read_el(0);
      // 2: x + x = 0
      opnd[0] = 8'h3C; opnd[1] = 8'h05;
      write_el(OP_LOAD, 0, 0);
      write_el(OP_XOR, 0, 0);
      chk("t2_acc_zero", acc_zero, 1);
      read_el(0);
      // 3: gapped load with X in masked bits
      opnd[0] = 8'h5A; opnd[1] = 8'h96;
      write_el(OP_LOAD, 1, 1);
      read_el(0);
      // 4: stalled read, then reset in the middle of an XOR
      read_el(1);
      opnd[0] = 8'h11; opnd[1] = 8'h02;
      cmd(OP_XOR);
      in_valid = 1; in_data = opnd[0];
      @(negedge clk);
      in_data = opnd[1];
      rst = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_acc_zero", acc_zero, 1);
      chk("midrst_cmd_ready", cmd_ready, 0);
      chk("midrst_in_ready", in_ready, 0);
      in_valid = 0;
      @(negedge clk);
      rst = 0;
      #1;
      chk("midrst_rel_ready", cmd_ready, 1);
      chk("midrst_rel_busy", busy, 0);
      model_clear();
      read_el(0);
      // 5: M=163 add of two random elements, then CLEAR
      sel = 1; nw = 21; tmask = 8'h07;
      for (int i = 0; i < 21; i++) opnd[i] = 8'($urandom);
      write_el(OP_LOAD, 0, 0);
      for (int i = 0; i < 21; i++) opnd[i] = 8'($urandom);
      opnd[20] = opnd[20] | 8'hF8;
      write_el(OP_XOR, 0, 0);
      read_el(0);
      opnd[0] = 8'h01;
      for (int i = 1; i < 21; i++) opnd[i] = 8'h00;
      write_el(OP_XOR, 0, 0);
      chk("t5_pre_clear_nonzero", acc_zero, 0);
      cmd(OP_CLEAR);
      model_clear();
      chk("clear_cmd_ready", cmd_ready, 1);
      chk("clear_busy", busy, 0);
      chk("clear_acc_zero", acc_zero, 1);
      read_el(0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
